// File: rtl/dcache_mem_arbiter.sv
// Round-robin arbiter between the data cache's per-consumer request slots and a
// smaller set of memory channels, each running its own request/relay handshake FSM.
module dcache_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_ready,
  output logic [NUM_CHANNELS-1:0][2:0]             channel_state
);

  // Handshake: a consumer holds valid until it sees ready, then drops valid; ready
  // stays up until valid is sampled low. Toward memory the channel holds valid and
  // the latched address/data until memory pulses ready; ready outside WAITING is ignored.

  localparam int SW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    READ_WAITING   = 3'd1,
    WRITE_WAITING  = 3'd2,
    READ_RELAYING  = 3'd3,
    WRITE_RELAYING = 3'd4
  } state_t;

  state_t [NUM_CHANNELS-1:0]           state_q, state_d;
  logic   [NUM_CHANNELS-1:0][SW-1:0]   slot_q, slot_d;
  logic   [NUM_CONSUMERS-1:0]          held_q, held_d, held_vis;
  logic   [SW-1:0]                     rr_q, rr_d, idx, pick;
  logic                                found;

  logic [NUM_CONSUMERS-1:0]                consumer_read_ready_d, consumer_write_ready_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data_d;
  logic [NUM_CHANNELS-1:0]                 mem_read_valid_d, mem_write_valid_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address_d, mem_write_address_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data_d;

  // held_vis tracks grants made earlier in this cycle; releases only land in held_d,
  // so a slot freed this cycle stays invisible until the next one.
  always_comb begin
    state_d                = state_q;
    slot_d                 = slot_q;
    held_d                 = held_q;
    held_vis               = held_q;
    rr_d                   = rr_q;
    consumer_read_ready_d  = consumer_read_ready;
    consumer_write_ready_d = consumer_write_ready;
    consumer_read_data_d   = consumer_read_data;
    mem_read_valid_d       = mem_read_valid;
    mem_write_valid_d      = mem_write_valid;
    mem_read_address_d     = mem_read_address;
    mem_write_address_d    = mem_write_address;
    mem_write_data_d       = mem_write_data;
    found                  = 1'b0;
    pick                   = '0;
    idx                    = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      pick  = '0;
      case (state_q[c])
        IDLE: begin
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
            idx = SW'((int'(rr_q) + k) % NUM_CONSUMERS);
            if (!found && !held_vis[idx] &&
                (consumer_write_valid[idx] || consumer_read_valid[idx])) begin
              found = 1'b1;
              pick  = idx;
            end
          end
          if (found) begin
            held_vis[pick] = 1'b1;
            held_d[pick]   = 1'b1;
            slot_d[c]      = pick;
            rr_d           = SW'((int'(pick) + 1) % NUM_CONSUMERS);
            if (consumer_write_valid[pick]) begin
              mem_write_valid_d[c]   = 1'b1;
              mem_write_address_d[c] = consumer_write_address[pick];
              mem_write_data_d[c]    = consumer_write_data[pick];
              state_d[c]             = WRITE_WAITING;
            end else begin
              mem_read_valid_d[c]   = 1'b1;
              mem_read_address_d[c] = consumer_read_address[pick];
              state_d[c]            = READ_WAITING;
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[c]) begin
            mem_read_valid_d[c]                 = 1'b0;
            consumer_read_data_d[slot_q[c]]     = mem_read_data[c];
            consumer_read_ready_d[slot_q[c]]    = 1'b1;
            state_d[c]                          = READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[c]) begin
            mem_write_valid_d[c]              = 1'b0;
            consumer_write_ready_d[slot_q[c]] = 1'b1;
            state_d[c]                        = WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[slot_q[c]]) begin
            consumer_read_ready_d[slot_q[c]] = 1'b0;
            held_d[slot_q[c]]                = 1'b0;
            state_d[c]                       = IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[slot_q[c]]) begin
            consumer_write_ready_d[slot_q[c]] = 1'b0;
            held_d[slot_q[c]]                 = 1'b0;
            state_d[c]                        = IDLE;
          end
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q              <= {NUM_CHANNELS{IDLE}};
      slot_q               <= '0;
      held_q               <= '0;
      rr_q                 <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
      mem_read_valid       <= '0;
      mem_write_valid      <= '0;
      mem_read_address     <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      state_q              <= state_d;
      slot_q               <= slot_d;
      held_q               <= held_d;
      rr_q                 <= rr_d;
      consumer_read_ready  <= consumer_read_ready_d;
      consumer_write_ready <= consumer_write_ready_d;
      consumer_read_data   <= consumer_read_data_d;
      mem_read_valid       <= mem_read_valid_d;
      mem_write_valid      <= mem_write_valid_d;
      mem_read_address     <= mem_read_address_d;
      mem_write_address    <= mem_write_address_d;
      mem_write_data       <= mem_write_data_d;
    end
  end

  always_comb begin
    channel_state = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) channel_state[c] = state_q[c];
  end

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// Directed bench for dcache_mem_arbiter: a 2-channel instance for the main scenarios
// and a 1-channel instance for round-robin fairness, against a small memory responder.
module tb_dcache_mem_arbiter;

  logic clk;
  logic reset;

  // 2-channel instance
  logic [7:0]      consumer_read_valid;
  logic [7:0][7:0] consumer_read_address;
  logic [7:0]      consumer_read_ready;
  logic [7:0][7:0] consumer_read_data;
  logic [7:0]      consumer_write_valid;
  logic [7:0][7:0] consumer_write_address;
  logic [7:0][7:0] consumer_write_data;
  logic [7:0]      consumer_write_ready;
  logic [1:0]      mem_read_valid;
  logic [1:0][7:0] mem_read_address;
  logic [1:0]      mem_read_ready;
  logic [1:0][7:0] mem_read_data;
  logic [1:0]      mem_write_valid;
  logic [1:0][7:0] mem_write_address;
  logic [1:0][7:0] mem_write_data;
  logic [1:0]      mem_write_ready;
  logic [1:0][2:0] channel_state;

  // 1-channel instance
  logic [7:0]      r_read_valid;
  logic [7:0][7:0] r_read_address;
  logic [7:0]      r_read_ready;
  logic [7:0][7:0] r_read_data;
  logic [7:0]      r_write_valid;
  logic [7:0][7:0] r_write_address;
  logic [7:0][7:0] r_write_data;
  logic [7:0]      r_write_ready;
  logic [0:0]      r_mem_read_valid;
  logic [0:0][7:0] r_mem_read_address;
  logic [0:0]      r_mem_read_ready;
  logic [0:0][7:0] r_mem_read_data;
  logic [0:0]      r_mem_write_valid;
  logic [0:0][7:0] r_mem_write_address;
  logic [0:0][7:0] r_mem_write_data;
  logic [0:0]      r_mem_write_ready;
  logic [0:0][2:0] r_channel_state;

  dcache_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(2)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid), .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .channel_state(channel_state)
  );

  dcache_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(1)) dut1 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(r_read_valid), .consumer_read_address(r_read_address),
    .consumer_read_ready(r_read_ready), .consumer_read_data(r_read_data),
    .consumer_write_valid(r_write_valid), .consumer_write_address(r_write_address),
    .consumer_write_data(r_write_data), .consumer_write_ready(r_write_ready),
    .mem_read_valid(r_mem_read_valid), .mem_read_address(r_mem_read_address),
    .mem_read_ready(r_mem_read_ready), .mem_read_data(r_mem_read_data),
    .mem_write_valid(r_mem_write_valid), .mem_write_address(r_mem_write_address),
    .mem_write_data(r_mem_write_data), .mem_write_ready(r_mem_write_ready),
    .channel_state(r_channel_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  int         mem_delay;
  int         rcnt [2];
  int         wcnt [2];
  int         r1cnt;
  logic [7:0] wmem [256];

  always_comb begin
    for (int c = 0; c < 2; c++) mem_read_data[c] = mem_read_address[c] ^ 8'h76;
    r_mem_read_data[0] = r_mem_read_address[0] ^ 8'h76;
  end

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      mem_read_ready  = '0;
      mem_write_ready = '0;
      for (int c = 0; c < 2; c++) begin
        rcnt[c] = 0;
        wcnt[c] = 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (mem_read_valid[c] && !mem_read_ready[c]) begin
          if (rcnt[c] >= mem_delay) mem_read_ready[c] = 1'b1;
          else rcnt[c]++;
        end else begin
          mem_read_ready[c] = 1'b0;
          rcnt[c] = 0;
        end
        if (mem_write_valid[c] && !mem_write_ready[c]) begin
          if (wcnt[c] >= mem_delay) begin
            mem_write_ready[c] = 1'b1;
            wmem[mem_write_address[c]] = mem_write_data[c];
          end else wcnt[c]++;
        end else begin
          mem_write_ready[c] = 1'b0;
          wcnt[c] = 0;
        end
      end
    end
  end

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_read_ready = '0;
      r1cnt = 0;
    end else if (r_mem_read_valid[0] && !r_mem_read_ready[0]) begin
      if (r1cnt >= mem_delay) r_mem_read_ready[0] = 1'b1;
      else r1cnt++;
    end else begin
      r_mem_read_ready[0] = 1'b0;
      r1cnt = 0;
    end
  end

  // ---------------- scoreboard ----------------
  // entry: {is_write, slot[2:0], addr[7:0], data[7:0]}
  logic [19:0] exp_q[$];
  logic [19:0] exp1_q[$];
  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [19:0] obs);
    logic [19:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s unexpected completion observed=%0h expected=none", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue_read(input int s, input logic [7:0] a);
    consumer_read_address[s] = a;
    consumer_read_valid[s]   = 1'b1;
    exp_q.push_back({1'b0, 3'(s), a, a ^ 8'h76});
  endtask

  task automatic issue_write(input int s, input logic [7:0] a, input logic [7:0] d);
    consumer_write_address[s] = a;
    consumer_write_data[s]    = d;
    consumer_write_valid[s]   = 1'b1;
    exp_q.push_back({1'b1, 3'(s), a, d});
  endtask

  // Consumer side: on ready, score the completion and drop valid.
  task automatic agent();
    for (int s = 0; s < 8; s++) begin
      if (consumer_read_valid[s] && consumer_read_ready[s]) begin
        pop_check("read_done", {1'b0, 3'(s), consumer_read_address[s], consumer_read_data[s]});
        consumer_read_valid[s] = 1'b0;
      end
      if (consumer_write_valid[s] && consumer_write_ready[s]) begin
        pop_check("write_done",
                  {1'b1, 3'(s), consumer_write_address[s], wmem[consumer_write_address[s]]});
        consumer_write_valid[s] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    agent();
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    check(tag, exp_q.size(), 0);
    repeat (3) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    consumer_read_valid  = '0;
    consumer_write_valid = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int rem [2];
    int n;
    int s;
    logic [19:0] e;
    checks = 0;
    errors = 0;
    mem_delay = 0;
    for (int i = 0; i < 256; i++) wmem[i] = 8'h00;
    consumer_read_valid = '0;  consumer_read_address = '0;
    consumer_write_valid = '0; consumer_write_address = '0; consumer_write_data = '0;
    r_read_valid = '0;  r_read_address = '0;
    r_write_valid = '0; r_write_address = '0; r_write_data = '0;
    r_mem_write_ready = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_mem_read_valid", mem_read_valid, 0);
    check("rst_mem_write_valid", mem_write_valid, 0);
    check("rst_cons_read_ready", consumer_read_ready, 0);
    check("rst_cons_write_ready", consumer_write_ready, 0);
    check("rst_channel_state", channel_state, 0);
    check("rst_r_mem_read_valid", r_mem_read_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // single read: slot 3, addr 0x2A -> 0x5C
    @(negedge clk);
    issue_read(3, 8'h2A);
    step();
    check("rd_mem_valid", mem_read_valid, 2'b01);
    check("rd_mem_addr", mem_read_address[0], 8'h2A);
    check("rd_ready_early", consumer_read_ready[3], 1'b0);
    @(negedge clk);
    check("rd_ready_2cyc", consumer_read_ready[3], 1'b1);
    check("rd_data", consumer_read_data[3], 8'h5C);
    check("rd_mem_valid_drop", mem_read_valid, 2'b00);
    agent();
    step();
    check("rd_ready_clear", consumer_read_ready[3], 1'b0);
    wait_drain("rd_drain", 10);

    // single write: slot 5, 0x77 -> 0x10
    issue_write(5, 8'h10, 8'h77);
    step();
    check("wr_mem_valid", mem_write_valid, 2'b01);
    check("wr_mem_addr", mem_write_address[0], 8'h10);
    check("wr_mem_data", mem_write_data[0], 8'h77);
    @(negedge clk);
    check("wr_ready", consumer_write_ready[5], 1'b1);
    agent();
    step();
    check("wr_ready_clear", consumer_write_ready[5], 1'b0);
    wait_drain("wr_drain", 10);

    // write beats read in the same slot; data held through a 5-cycle memory delay
    mem_delay = 4;
    issue_write(2, 8'h40, 8'hA5);
    issue_read(2, 8'h41);
    step();
    consumer_write_data[2] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      check("prio_write_valid", mem_write_valid, 2'b01);
      check("prio_read_held_off", mem_read_valid, 2'b00);
      check("prio_write_data", mem_write_data[0], 8'hA5);
      check("prio_write_addr", mem_write_address[0], 8'h40);
      step();
    end
    wait_drain("prio_drain", 40);

    // reset in the middle of an outstanding read
    mem_delay = 20;
    consumer_read_address[0] = 8'h11;
    consumer_read_valid[0]   = 1'b1;
    step();
    check("mid_rst_pending", mem_read_valid[0], 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_mem_valid", mem_read_valid, 2'b00);
    check("mid_rst_cons_ready", consumer_read_ready, 8'h00);
    consumer_read_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    mem_delay = 0;
    issue_read(0, 8'h30);
    issue_read(3, 8'h33);
    step();
    check("post_rst_ch0_addr", mem_read_address[0], 8'h30);
    check("post_rst_ch1_addr", mem_read_address[1], 8'h33);
    wait_drain("post_rst_drain", 20);

    // contention: all 8 slots at once, served in pairs from slot 0
    do_reset();
    mem_delay = 0;
    for (int i = 0; i < 8; i++) issue_read(i, 8'h80 + 8'(i));
    step();
    check("cont_first_pair", {mem_read_address[1], mem_read_address[0]}, 16'h8180);
    wait_drain("cont_drain", 100);

    // round-robin on a single channel: slots 0 and 7 alternate
    mem_delay = 0;
    for (int i = 0; i < 3; i++) begin
      exp1_q.push_back({1'b0, 3'd0, 8'h05, 8'h05 ^ 8'h76});
      exp1_q.push_back({1'b0, 3'd7, 8'h75, 8'h75 ^ 8'h76});
    end
    rem[0] = 3;
    rem[1] = 3;
    r_read_address[0] = 8'h05;
    r_read_address[7] = 8'h75;
    r_read_valid[0] = 1'b1;
    r_read_valid[7] = 1'b1;
    n = 0;
    while (exp1_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
      for (int j = 0; j < 2; j++) begin
        s = j * 7;
        if (r_read_valid[s] && r_read_ready[s]) begin
          if (exp1_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL rr_extra observed=slot%0d expected=none", s);
          end else begin
            e = exp1_q.pop_front();
            check("rr_order", {1'b0, 3'(s), r_read_address[s], r_read_data[s]}, e);
          end
          r_read_valid[s] = 1'b0;
          rem[j]--;
        end else if (!r_read_valid[s] && !r_read_ready[s] && rem[j] > 0) begin
          r_read_valid[s] = 1'b1;
        end
      end
    end
    check("rr_drain", exp1_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
